// File: rtl/fifo_pkt_framer_if.sv
// Handshake bundle between the framer, its upstream sync FIFO and the byte sink.
// master is the framer side; slave is the FIFO/sink side.
interface fifo_pkt_framer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_empty;
  logic                  rd_en;
  logic                  rd_vld;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_last;

  modport master (
    input  fifo_empty, rd_vld, fifo_data, tx_ready,
    output rd_en, tx_valid, tx_data, tx_last
  );

  modport slave (
    output fifo_empty, rd_vld, fifo_data, tx_ready,
    input  rd_en, tx_valid, tx_data, tx_last
  );
endinterface

// File: rtl/fifo_pkt_framer.sv
// Pulls up to PKT_LEN bytes from a sync FIFO and emits A5 | len | payload | checksum,
// flushing a partial packet after TIMEOUT idle cycles.
module fifo_pkt_framer #(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                clk,
  input  logic                rstn,
  fifo_pkt_framer_if.master   bus,
  output logic                busy,
  output logic [15:0]         pkt_count
);
  localparam logic [3:0] PLEN = 4'(PKT_LEN);
  localparam logic [7:0] TOUT = 8'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, COLLECT, HDR, LEN, PAY, CSUM} state_t;

  state_t                state_q, state_d;
  logic [3:0]            req_cnt_q, req_cnt_d;
  logic [3:0]            cap_cnt_q, cap_cnt_d;
  logic [3:0]            idx_q, idx_d;
  logic [7:0]            to_cnt_q, to_cnt_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic [15:0]           pkt_count_q, pkt_count_d;
  logic [DATA_WIDTH-1:0] pbuf_q [0:15];
  logic                  cap_we;
  logic                  rd_en_c, tx_valid_c, tx_last_c;
  logic [DATA_WIDTH-1:0] tx_data_c;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      req_cnt_q   <= '0;
      cap_cnt_q   <= '0;
      idx_q       <= '0;
      to_cnt_q    <= '0;
      sum_q       <= '0;
      pkt_count_q <= '0;
    end else begin
      req_cnt_q   <= req_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      idx_q       <= idx_d;
      to_cnt_q    <= to_cnt_d;
      sum_q       <= sum_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  // Payload store needs no reset: it is only read at indices written this packet.
  always_ff @(posedge clk) begin
    if (cap_we) pbuf_q[cap_cnt_q] <= bus.fifo_data;
  end

  always_comb begin
    state_d     = state_q;
    req_cnt_d   = req_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    idx_d       = idx_q;
    to_cnt_d    = to_cnt_q;
    sum_d       = sum_q;
    pkt_count_d = pkt_count_q;
    cap_we      = 1'b0;
    rd_en_c     = 1'b0;
    tx_valid_c  = 1'b0;
    tx_last_c   = 1'b0;
    tx_data_c   = '0;
    unique case (state_q)
      IDLE: if (!bus.fifo_empty) state_d = COLLECT;
      COLLECT: begin
        rd_en_c = !bus.fifo_empty && (req_cnt_q < PLEN);
        if (rd_en_c) req_cnt_d = req_cnt_q + 4'd1;
        if (bus.rd_vld && (cap_cnt_q < PLEN)) begin
          cap_we    = 1'b1;
          cap_cnt_d = cap_cnt_q + 4'd1;
          sum_d     = sum_q + bus.fifo_data;
        end
        if (rd_en_c || bus.rd_vld) to_cnt_d = '0;
        else if (to_cnt_q != TOUT) to_cnt_d = to_cnt_q + 8'd1;
        // A read issued this cycle would be orphaned, so the flush waits for it.
        if ((cap_cnt_q == PLEN) ||
            ((to_cnt_q == TOUT) && (cap_cnt_q == req_cnt_q) &&
             (cap_cnt_q != 4'd0) && !rd_en_c))
          state_d = HDR;
      end
      HDR: begin
        tx_valid_c = 1'b1;
        tx_data_c  = DATA_WIDTH'(8'hA5);
        if (bus.tx_ready) state_d = LEN;
      end
      LEN: begin
        tx_valid_c = 1'b1;
        tx_data_c  = DATA_WIDTH'(cap_cnt_q);
        if (bus.tx_ready) begin
          state_d = PAY;
          idx_d   = '0;
        end
      end
      PAY: begin
        tx_valid_c = 1'b1;
        tx_data_c  = pbuf_q[idx_q];
        if (bus.tx_ready) begin
          idx_d = idx_q + 4'd1;
          if (idx_q == cap_cnt_q - 4'd1) state_d = CSUM;
        end
      end
      CSUM: begin
        tx_valid_c = 1'b1;
        tx_last_c  = 1'b1;
        tx_data_c  = sum_q + DATA_WIDTH'(cap_cnt_q);
        if (bus.tx_ready) begin
          state_d     = IDLE;
          pkt_count_d = pkt_count_q + 16'd1;
          req_cnt_d   = '0;
          cap_cnt_d   = '0;
          idx_d       = '0;
          to_cnt_d    = '0;
          sum_d       = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rd_en    = rd_en_c;
  assign bus.tx_valid = tx_valid_c;
  assign bus.tx_data  = tx_data_c;
  assign bus.tx_last  = tx_last_c;
  assign busy         = (state_q != IDLE);
  assign pkt_count    = pkt_count_q;
endmodule

// File: tb/tb_fifo_pkt_framer.sv
// Bench: FIFO model upstream, scoreboard of expected bytes checked at each accepted handshake.
module tb_fifo_pkt_framer;
  localparam int PL = 4;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        busy;
  logic [15:0] pkt_count;

  fifo_pkt_framer_if #(.DATA_WIDTH(8)) bus ();

  fifo_pkt_framer #(.DATA_WIDTH(8), .PKT_LEN(PL), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .bus(bus), .busy(busy), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Upstream FIFO: one-cycle read latency; reads of an empty FIFO are flagged.
  logic [7:0] mem [0:63];
  int wp = 0;
  int rp = 0;
  int bad_rd = 0;
  assign bus.fifo_empty = (wp == rp);

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.rd_vld    <= 1'b0;
      bus.fifo_data <= 8'h00;
    end else begin
      bus.rd_vld <= 1'b0;
      if (bus.rd_en) begin
        if (wp == rp) bad_rd <= bad_rd + 1;
        else begin
          bus.fifo_data <= mem[rp % 64];
          bus.rd_vld    <= 1'b1;
          rp            <= rp + 1;
        end
      end
    end
  end

  typedef struct packed {logic [7:0] d; logic l;} exp_t;
  exp_t       sbq[$];
  bit         sb_en = 1'b1;
  int         acc_cnt = 0;
  bit         hold_v = 1'b0;
  logic [7:0] hold_d;
  logic       hold_l;

  // Inputs move at posedge+1, so values seen at negedge are those the next posedge samples.
  always @(negedge clk) begin
    exp_t e;
    if (rstn && bus.tx_valid) begin
      if (hold_v) begin
        chk("stall_data", bus.tx_data, hold_d);
        chk("stall_last", bus.tx_last, hold_l);
      end
      if (bus.tx_ready) begin
        hold_v = 1'b0;
        acc_cnt++;
        if (sb_en) begin
          if (sbq.size() == 0) begin
            checks++;
            errs++;
            $display("FAIL unexpected_byte: got %0h expected none", bus.tx_data);
          end else begin
            e = sbq.pop_front();
            chk("tx_data", bus.tx_data, e.d);
            chk("tx_last", bus.tx_last, e.l);
          end
        end
      end else begin
        hold_v = 1'b1;
        hold_d = bus.tx_data;
        hold_l = bus.tx_last;
      end
    end else hold_v = 1'b0;
  end

  int rdy_mode = 0;  // 0: always ready, 1: toggle, 2: never
  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       bus.tx_ready = 1'b1;
        1:       bus.tx_ready = ~bus.tx_ready;
        default: bus.tx_ready = 1'b0;
      endcase
    end
  end

  typedef struct {
    logic [7:0] b [4];
    int         n;
    int         mode;
    logic [7:0] csum;
  } vec_t;
  vec_t        vt [7];
  logic [15:0] exp_pkt = 16'h0000;

  task automatic push_bytes(input vec_t v);
    for (int i = 0; i < v.n; i++) begin
      mem[wp % 64] = v.b[i];
      wp++;
    end
  endtask

  task automatic run_pkt(input vec_t v, input string nm);
    int lat;
    rdy_mode = v.mode;
    sbq.push_back('{d: 8'hA5, l: 1'b0});
    sbq.push_back('{d: 8'(v.n), l: 1'b0});
    for (int i = 0; i < v.n; i++) sbq.push_back('{d: v.b[i], l: 1'b0});
    sbq.push_back('{d: v.csum, l: 1'b1});
    exp_pkt = exp_pkt + 16'd1;
    push_bytes(v);
    lat = 0;
    while (!bus.tx_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (v.n == PL) chk({nm, "_lat_full"}, 32'(lat < TO), 1);
    else           chk({nm, "_lat_timeout"}, 32'(lat >= TO && lat < 200), 1);
    lat = 0;
    while (sbq.size() != 0 && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_drained"}, sbq.size(), 0);
    repeat (2) begin @(posedge clk); #1; end
    chk({nm, "_pkt_count"}, pkt_count, exp_pkt);
    chk({nm, "_idle"}, busy, 0);
    rdy_mode = 0;
  endtask

  initial begin
    int lat;
    int base;
    vt[0].b = '{8'h01, 8'h02, 8'h03, 8'h04}; vt[0].n = 4; vt[0].mode = 0; vt[0].csum = 8'h0E;
    vt[1].b = '{8'h10, 8'h20, 8'h00, 8'h00}; vt[1].n = 2; vt[1].mode = 0; vt[1].csum = 8'h32;
    vt[2].b = '{8'h01, 8'h02, 8'h03, 8'h04}; vt[2].n = 4; vt[2].mode = 1; vt[2].csum = 8'h0E;
    vt[3].b = '{8'hFF, 8'hFF, 8'hFF, 8'hFF}; vt[3].n = 4; vt[3].mode = 0; vt[3].csum = 8'h00;
    vt[4].b = '{8'h80, 8'h7F, 8'h01, 8'h00}; vt[4].n = 4; vt[4].mode = 1; vt[4].csum = 8'h04;
    vt[5].b = '{8'h5A, 8'h00, 8'h00, 8'h00}; vt[5].n = 1; vt[5].mode = 0; vt[5].csum = 8'h5B;
    vt[6].b = '{8'h11, 8'h22, 8'h33, 8'h00}; vt[6].n = 3; vt[6].mode = 1; vt[6].csum = 8'h69;

    #1;
    chk("rst_rd_en", bus.rd_en, 0);
    chk("rst_tx_valid", bus.tx_valid, 0);
    chk("rst_tx_last", bus.tx_last, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pkt_count", pkt_count, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_pkt(vt[i], $sformatf("vec%0d", i));

    // Abort mid-payload with an asynchronous reset.
    sb_en = 1'b0;
    base = acc_cnt;
    vt[0].b = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    push_bytes(vt[0]);
    lat = 0;
    while (acc_cnt < base + 3 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("midpay_busy", busy, 1);
    chk("midpay_valid", bus.tx_valid, 1);
    rstn = 1'b0;
    #1;
    chk("arst_tx_valid", bus.tx_valid, 0);
    chk("arst_tx_last", bus.tx_last, 0);
    chk("arst_tx_data", bus.tx_data, 0);
    chk("arst_busy", busy, 0);
    chk("arst_rd_en", bus.rd_en, 0);
    chk("arst_pkt_count", pkt_count, 0);
    wp = rp;
    exp_pkt = 16'h0000;
    @(negedge clk) rstn = 1'b1;
    sb_en = 1'b1;
    vt[0].b = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_pkt(vt[0], "post_rst");

    // Counter wrap.
    force dut.pkt_count_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.pkt_count_q;
    chk("forced_count", pkt_count, 16'hFFFF);
    exp_pkt = 16'hFFFF;
    run_pkt(vt[3], "wrap");
    chk("wrap_zero", pkt_count, 16'h0000);

    chk("no_empty_read", bad_rd, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/fifo_pkt_framer.md
FIFO_PKT_FRAMER -- requirements
Module: fifo_pkt_framer

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, width of the FIFO data and tx_data; fixed at 8 for this block.
REQ-002 Parameter: PKT_LEN, default 4, maximum payload bytes per packet; legal range 1..15.
REQ-003 Parameter: TIMEOUT, default 16, idle cycles in COLLECT before a partial packet is flushed; legal range 2..255.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rstn  input  1  reset, asynchronous assert, active-low.
REQ-006 fifo_empty  input  1  empty flag from the upstream sync FIFO.
REQ-007 rd_en  output  1  read request to the upstream FIFO.
REQ-008 rd_vld  input  1  FIFO read-data valid; arrives one cycle after an accepted rd_en.
REQ-009 fifo_data  input  8  FIFO read data; valid only when rd_vld=1.
REQ-010 tx_valid  output  1  outgoing byte valid.
REQ-011 tx_ready  input  1  downstream accepts the byte when tx_valid&&tx_ready.
REQ-012 tx_data  output  8  outgoing packet byte.
REQ-013 tx_last  output  1  marks the checksum (final) byte of a packet.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 pkt_count  output  16  count of completed packets.

Function
REQ-016 FSM states SHALL be IDLE, COLLECT, HDR, LEN, PAY and CSUM.
REQ-017 IDLE -> COLLECT SHALL occur when fifo_empty=0; otherwise the FSM SHALL remain in IDLE.
REQ-018 rd_en SHALL be (state==COLLECT) && !fifo_empty && (req_cnt<PKT_LEN); req_cnt increments on each rd_en.
REQ-019 On each rd_vld in COLLECT, fifo_data SHALL be stored to buf[cap_cnt] and cap_cnt incremented; rd_vld outside COLLECT SHALL be ignored.
REQ-020 The timeout counter SHALL clear on rd_en or rd_vld, and increment on every other COLLECT cycle.
REQ-021 COLLECT -> HDR SHALL occur when cap_cnt==PKT_LEN, or when the timeout counter reaches TIMEOUT with cap_cnt==req_cnt>=1.
REQ-022 The packet SHALL be sent in order: header 8'hA5, length byte {4'h0,cap_cnt}, cap_cnt payload bytes in FIFO order, then the checksum.
REQ-023 The checksum SHALL be the modulo-256 sum of the length byte and all payload bytes (carry discarded).
REQ-024 tx_valid SHALL be 1 in HDR, LEN, PAY and CSUM; each state advances only on tx_valid&&tx_ready.
REQ-025 tx_data and tx_last SHALL hold stable while tx_valid=1 and tx_ready=0.
REQ-026 tx_last SHALL be 1 only in CSUM.
REQ-027 When the CSUM byte is accepted: pkt_count SHALL increment (0xFFFF wraps to 0x0000); counters SHALL clear; the FSM SHALL go to IDLE.
REQ-028 Zero-length packets SHALL never be emitted; COLLECT with cap_cnt=0 SHALL wait indefinitely.
REQ-029 No FIFO read SHALL occur outside COLLECT, even if fifo_empty=0.

Reset
REQ-030 While rstn=0, all of the following SHALL hold regardless of clk: state=IDLE; rd_en, tx_valid, tx_last, busy = 0; tx_data=8'h00; pkt_count=0; req_cnt, cap_cnt, timeout counter = 0.
REQ-031 Reset asserted mid-packet SHALL abort the packet with no completion pulse; the first byte after release SHALL be a new header.

Verification
REQ-032 FIFO holds 01,02,03,04; tx_ready=1 -> stream A5,04,01,02,03,04,0E; tx_last only on 0E; pkt_count=1.
REQ-033 FIFO holds only 10,20 and stays empty -> flush after 16 idle cycles; stream A5,02,10,20,32.
REQ-034 Full packet with tx_ready toggled 1/0 each cycle -> identical byte stream; tx_data stable during every stall cycle.
REQ-035 Payload FF,FF,FF,FF -> checksum 8'h00 (04+3FC mod 256).
REQ-036 Assert rstn=0 during PAY -> outputs at reset values immediately; after release, next bytes start with A5; pkt_count=0.
REQ-037 Preload pkt_count to 0xFFFF (force) and complete one packet -> pkt_count=0x0000.
